// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and receiver state encoding
package spi_pkg;

    localparam int SPI_DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } spi_rx_state_e;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop synchroniser for one asynchronous input bit
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave receiver, LSB first, one-word output buffer
// Optional abort pulse output enabled by macro SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d, mosi_d;
    logic sclk_rise;
    logic cs_fall;
    logic last_bit;

    spi_rx_state_e state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shift;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk), .rst (rst), .d (sclk), .q (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk), .rst (rst), .d (cs), .q (cs_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk), .rst (rst), .d (mosi), .q (mosi_s)
    );

    // The rise pulse is registered, so mosi_d is the sample aligned with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            mosi_d    <= 1'b0;
            sclk_rise <= 1'b0;
        end else begin
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            mosi_d    <= mosi_s;
            sclk_rise <= sclk_s & ~sclk_d & ~cs_s;
        end
    end

    assign cs_fall  = cs_d & ~cs_s;
    assign last_bit = sclk_rise && (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cs_fall needs cs_d high, so a cs held low after LOAD cannot re-arm.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = LOAD;
                end else if (cs_s) begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            shift      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (state == IDLE && cs_fall) begin
                cnt <= '0;
            end else if (state == SHIFT && sclk_rise) begin
                shift[cnt] <= mosi_d;
                cnt        <= cnt + CNT_W'(1);
            end

            // A load wins over consumption: the buffer is refilled, never emptied.
            if (state == LOAD) begin
                dout       <= shift;
                dout_valid <= 1'b1;
                if (dout_valid && !dout_ready) begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic abort;

    assign abort = (state == SHIFT) && cs_s && !last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - directed and scoreboarded bench for spi_slave_rx
module tb_spi_slave_rx;

    localparam int DW = 12;
    localparam int SS = 2;
    localparam int PH = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          cs;
    logic          mosi;
    logic          dout_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          overrun;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic          frame_err;
    int            fe_count = 0;
    int            fe_before;
`endif

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err  (frame_err),
`endif
        .overrun    (overrun)
    );

    typedef struct {
        logic [DW-1:0] din;
        logic          rdy;
        logic [DW-1:0] exp_dout;
        logic          exp_valid;
        logic          exp_ovr;
    } vec_t;

    vec_t          tbl [6];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            vcount;
    int            vfirst;
    int            rise_cyc;
    bit            rand_ready = 1'b0;
    bit            sb_en = 1'b0;
    logic [DW-1:0] sb_exp;
    int            sb_consumed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change just after a falling edge; a handshake seen here happens at the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
        if (dout_valid) begin
            vcount++;
            if (vfirst < 0) vfirst = cyc;
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err) fe_count++;
`endif
        if (sb_en && dout_valid && dout_ready) begin
            check("sb_word", 32'(dout), 32'(sb_exp));
            sb_consumed++;
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int nbits, input bit ready_at_load);
        cs = 1'b0;
        wait_ticks(PH);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[i];
            wait_ticks(PH);
            tick();
            sclk = 1'b1;
            rise_cyc = cyc;
            if (ready_at_load && i == nbits - 1) begin
                wait_ticks(4);
                dout_ready = 1'b1;
                tick();
                dout_ready = 1'b0;
                wait_ticks(PH - 5);
            end else begin
                wait_ticks(PH);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [DW-1:0] w, input bit ready_at_load);
        vcount = 0;
        vfirst = -1;
        send_bits(w, DW, ready_at_load);
        wait_ticks(PH);
        cs = 1'b1;
        wait_ticks(PH);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_ticks(2);
        rst = 1'b0;
        wait_ticks(2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{din: 12'hA5C, rdy: 1'b1, exp_dout: 12'hA5C, exp_valid: 1'b0, exp_ovr: 1'b0};
        tbl[1] = '{din: 12'h001, rdy: 1'b1, exp_dout: 12'h001, exp_valid: 1'b0, exp_ovr: 1'b0};
        tbl[2] = '{din: 12'hFFF, rdy: 1'b1, exp_dout: 12'hFFF, exp_valid: 1'b0, exp_ovr: 1'b0};
        tbl[3] = '{din: 12'h800, rdy: 1'b1, exp_dout: 12'h800, exp_valid: 1'b0, exp_ovr: 1'b0};
        tbl[4] = '{din: 12'h001, rdy: 1'b0, exp_dout: 12'h001, exp_valid: 1'b1, exp_ovr: 1'b0};
        tbl[5] = '{din: 12'hFFF, rdy: 1'b0, exp_dout: 12'hFFF, exp_valid: 1'b1, exp_ovr: 1'b1};

        rst        = 1'b1;
        cs         = 1'b1;
        sclk       = 1'b0;
        mosi       = 1'b0;
        dout_ready = 1'b0;
        wait_ticks(2);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        wait_ticks(2);

        for (int i = 0; i < 6; i++) begin
            dout_ready = tbl[i].rdy;
            frame(tbl[i].din, 1'b0);
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].exp_dout));
            check($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].exp_ovr));
            if (tbl[i].rdy) begin
                check($sformatf("vec%0d_valid_cycles", i), 32'(vcount), 32'd1);
                check($sformatf("vec%0d_latency", i), 32'(vfirst - rise_cyc), 32'(SS + 3));
            end
        end

        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        wait_ticks(2);
        check("ovr_consumed_valid", 32'(dout_valid), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);
        check("ovr_dout_hold", 32'(dout), 32'hFFF);

        do_reset();
        check("rst2_dout", 32'(dout), 32'h0);
        check("rst2_valid", 32'(dout_valid), 32'h0);
        check("rst2_overrun", 32'(overrun), 32'h0);

        // Aborted frame with a word still waiting in the buffer.
        frame(12'h3A7, 1'b0);
        check("abort_pre_valid", 32'(dout_valid), 32'h1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        fe_before = fe_count;
`endif
        send_bits(12'h0F0, 5, 1'b0);
        wait_ticks(PH);
        cs = 1'b1;
        wait_ticks(PH);
        check("abort_dout", 32'(dout), 32'h3A7);
        check("abort_valid", 32'(dout_valid), 32'h1);
        check("abort_overrun", 32'(overrun), 32'h0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("abort_frame_err_pulses", 32'(fe_count - fe_before), 32'd1);
`endif
        dout_ready = 1'b1;
        frame(12'h0C3, 1'b0);
        check("post_abort_dout", 32'(dout), 32'h0C3);
        check("post_abort_valid_cycles", 32'(vcount), 32'd1);

        // Reset in the middle of a frame.
`ifdef SPI_SLAVE_FRAME_ERR_EN
        fe_before = fe_count;
`endif
        send_bits(12'h3C3, 6, 1'b0);
        do_reset();
        check("midrst_dout", 32'(dout), 32'h0);
        frame(12'h5A5, 1'b0);
        check("midrst_next_dout", 32'(dout), 32'h5A5);
        check("midrst_next_valid_cycles", 32'(vcount), 32'd1);
        check("midrst_overrun", 32'(overrun), 32'h0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("midrst_frame_err_pulses", 32'(fe_count - fe_before), 32'd0);
`endif

        // Consumer accepts the old word exactly as the new one loads.
        dout_ready = 1'b0;
        frame(12'h111, 1'b0);
        check("ldrdy_pre_valid", 32'(dout_valid), 32'h1);
        frame(12'h222, 1'b1);
        check("ldrdy_dout", 32'(dout), 32'h222);
        check("ldrdy_valid", 32'(dout_valid), 32'h1);
        check("ldrdy_overrun", 32'(overrun), 32'h0);

        do_reset();
        rand_ready  = 1'b1;
        sb_en       = 1'b1;
        sb_consumed = 0;
        for (int k = 0; k < 20; k++) begin
            int n;
            sb_exp = 12'($urandom);
            frame(sb_exp, 1'b0);
            n = 0;
            while (dout_valid && n < 300) begin
                tick();
                n++;
            end
            check($sformatf("rand%0d_drained", k), 32'(dout_valid), 32'h0);
        end
        rand_ready = 1'b0;
        sb_en      = 1'b0;
        dout_ready = 1'b0;
        check("rand_consumed", 32'(sb_consumed), 32'd20);
        check("rand_overrun", 32'(overrun), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
